weight_noc_streamer: RTL and testbench

WEIGHT_NOC_STREAMER -- requirements
Module: weight_noc_streamer

---
 rtl/weight_noc_streamer.sv | 234 +++++++++++++++++++++++
 tb/tb_weight_noc_streamer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_noc_streamer.sv
`default_nettype none
// ============================================================================
// Module      : weight_noc_streamer
// Description : Walks a 4-D weight tensor (filter, channel, row, col) in the
//               GLB. It issues one read per word and packs the returned words
//               into tagged beats. A skid buffer holds beats for a
//               ready/valid NoC output.
// Revision    : 1.0 - initial release
// ============================================================================
module weight_noc_streamer #(
  parameter int DATA_WIDTH    = 16,
  parameter int PACK          = 4,
  parameter int ADDR_WIDTH    = 20,
  parameter int DIM_WIDTH     = 8,
  parameter int RD_LATENCY    = 1,
  parameter int SKID_BEATS    = 4,
  parameter int ROW_TAG_WIDTH = 4,
  parameter int COL_TAG_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [DIM_WIDTH-1:0]       num_f,
  input  logic [DIM_WIDTH-1:0]       num_c,
  input  logic [DIM_WIDTH-1:0]       R,
  input  logic [DIM_WIDTH-1:0]       S,
  input  logic [DIM_WIDTH-1:0]       r_grp,
  input  logic [DIM_WIDTH-1:0]       t_grp,
  output logic                       re,
  output logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [PACK-1:0]            out_mask,
  output logic [ROW_TAG_WIDTH-1:0]   row_tag,
  output logic [COL_TAG_WIDTH-1:0]   col_tag
);

  localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int RB_W   = 2 * DIM_WIDTH + ROW_TAG_WIDTH;
  localparam int CNT_W  = $clog2(SKID_BEATS + 1) + 1;
  localparam int PTR_W  = (SKID_BEATS > 1) ? $clog2(SKID_BEATS) : 1;
  localparam int SB_W   = LANE_W + 2 + ROW_TAG_WIDTH + COL_TAG_WIDTH;
  localparam int DW_ALL = DATA_WIDTH * PACK;
  localparam int ENT_W  = DW_ALL + PACK + COL_TAG_WIDTH + ROW_TAG_WIDTH + 1;
  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic                   zero_q, zero_d, done_q, done_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DIM_WIDTH-1:0]   nf_q, nf_d, nc_q, nc_d, nr_q, nr_d, ns_q, ns_d, rg_q, rg_d, tg_q, tg_d;
  logic [DIM_WIDTH-1:0]   f_q, f_d, c_q, c_d, row_q, row_d, col_q, col_d, cmod_q, cmod_d, fmod_q, fmod_d;
  logic [RB_W-1:0]        rowbase_q, rowbase_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [CNT_W-1:0]       resv_q, resv_d, cnt_q, cnt_d;
  logic [RD_LATENCY-1:0]  pipe_vld_q, pipe_vld_d;
  logic [SB_W-1:0]        pipe_sb_q [RD_LATENCY];
  logic [SB_W-1:0]        pipe_sb_d [RD_LATENCY];
  logic [DW_ALL-1:0]      pack_data_q, pack_data_d, merged_data;
  logic [PACK-1:0]        pack_mask_q, pack_mask_d, merged_mask;
  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [ENT_W-1:0]       mem_q [SKID_BEATS];

  // Issue-side decode of where the walk stands.
  logic                     last_col, last_row, last_c, last_f, last_issue, close_now;
  logic [ROW_TAG_WIDTH-1:0] rtag_now;
  logic [COL_TAG_WIDTH-1:0] ctag_now;
  logic [SB_W-1:0]          sb_now;
  // Return-side sideband of the word arriving on rdata this cycle.
  logic                     arr_vld, arr_close, arr_last;
  logic [SB_W-1:0]          arr_sb;
  logic [LANE_W-1:0]        arr_lane;
  logic [ROW_TAG_WIDTH-1:0] arr_rtag;
  logic [COL_TAG_WIDTH-1:0] arr_ctag;
  logic                     push, pop, pop_last;
  logic [ENT_W-1:0]         head, entry;

  assign last_col   = (col_q == ns_q - DIM_ONE);
  assign last_row   = (row_q == nr_q - DIM_ONE);
  assign last_c     = (c_q == nc_q - DIM_ONE);
  assign last_f     = (f_q == nf_q - DIM_ONE);
  assign last_issue = last_col && last_row && last_c && last_f;
  assign close_now  = (lane_q == LANE_W'(PACK - 1)) || last_col;
  assign rtag_now   = ROW_TAG_WIDTH'(rowbase_q + RB_W'(row_q));
  assign ctag_now   = COL_TAG_WIDTH'(fmod_q);
  assign sb_now     = {lane_q, close_now, last_issue, rtag_now, ctag_now};

  // A new beat is only opened while a buffer slot can be reserved for it.
  assign re   = (state_q == ISSUE) && ((lane_q != '0) || (resv_q < CNT_W'(SKID_BEATS)));
  assign addr = addr_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

  assign arr_vld   = pipe_vld_q[RD_LATENCY-1];
  assign arr_sb    = pipe_sb_q[RD_LATENCY-1];
  assign arr_ctag  = arr_sb[COL_TAG_WIDTH-1:0];
  assign arr_rtag  = arr_sb[COL_TAG_WIDTH +: ROW_TAG_WIDTH];
  assign arr_last  = arr_sb[COL_TAG_WIDTH + ROW_TAG_WIDTH];
  assign arr_close = arr_sb[COL_TAG_WIDTH + ROW_TAG_WIDTH + 1];
  assign arr_lane  = arr_sb[SB_W-1 -: LANE_W];

  assign push      = arr_vld && arr_close;
  assign head      = mem_q[rd_q];
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign pop_last  = pop && head[ENT_W-1];
  assign entry     = {arr_last, arr_rtag, arr_ctag, merged_mask, merged_data};

  assign out_data = out_valid ? head[DW_ALL-1:0] : '0;
  assign out_mask = out_valid ? head[DW_ALL +: PACK] : '0;
  assign col_tag  = out_valid ? head[DW_ALL + PACK +: COL_TAG_WIDTH] : '0;
  assign row_tag  = out_valid ? head[DW_ALL + PACK + COL_TAG_WIDTH +: ROW_TAG_WIDTH] : '0;

  // Merge the arriving word into its lane of the partially packed beat.
  always_comb begin
    merged_data = pack_data_q;
    merged_mask = pack_mask_q;
    merged_data[arr_lane*DATA_WIDTH +: DATA_WIDTH] = rdata;
    merged_mask[arr_lane] = 1'b1;
  end

  // Read-latency shift register carrying each read's beat sideband.
  always_comb begin
    pipe_vld_d[0] = re;
    pipe_sb_d[0]  = sb_now;
    for (int k = 1; k < RD_LATENCY; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_sb_d[k]  = pipe_sb_q[k-1];
    end
  end

  // Control FSM, index walk, packing and buffer bookkeeping.
  always_comb begin
    state_d = state_q;  zero_d = zero_q;  done_d = 1'b0;  addr_d = addr_q;
    nf_d = nf_q;  nc_d = nc_q;  nr_d = nr_q;  ns_d = ns_q;  rg_d = rg_q;  tg_d = tg_q;
    f_d = f_q;  c_d = c_q;  row_d = row_q;  col_d = col_q;  cmod_d = cmod_q;  fmod_d = fmod_q;
    rowbase_d = rowbase_q;  lane_d = lane_q;  resv_d = resv_q;  cnt_d = cnt_q;
    pack_data_d = pack_data_q;  pack_mask_d = pack_mask_q;  wr_d = wr_q;  rd_d = rd_q;
    case (state_q)
      IDLE: if (start) begin
        nf_d = num_f;  nc_d = num_c;  nr_d = R;  ns_d = S;
        rg_d = (r_grp == '0) ? DIM_ONE : r_grp;
        tg_d = (t_grp == '0) ? DIM_ONE : t_grp;
        addr_d = base_addr;
        f_d = '0;  c_d = '0;  row_d = '0;  col_d = '0;
        cmod_d = '0;  fmod_d = '0;  rowbase_d = '0;  lane_d = '0;
        if ((num_f == '0) || (num_c == '0) || (R == '0) || (S == '0)) begin
          state_d = DRAIN;  zero_d = 1'b1;  done_d = 1'b1;
        end else begin
          state_d = ISSUE;  zero_d = 1'b0;
        end
      end
      ISSUE: if (re) begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        lane_d = close_now ? '0 : lane_q + LANE_W'(1);
        col_d  = col_q + DIM_ONE;
        if (last_col) begin
          col_d = '0;
          row_d = row_q + DIM_ONE;
          if (last_row) begin
            row_d = '0;
            c_d   = c_q + DIM_ONE;
            if (cmod_q == rg_q - DIM_ONE) begin
              cmod_d = '0;  rowbase_d = '0;
            end else begin
              cmod_d = cmod_q + DIM_ONE;  rowbase_d = rowbase_q + RB_W'(nr_q);
            end
            if (last_c) begin
              c_d = '0;  cmod_d = '0;  rowbase_d = '0;
              f_d = f_q + DIM_ONE;
              fmod_d = (fmod_q == tg_q - DIM_ONE) ? '0 : fmod_q + DIM_ONE;
              if (last_f) state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: if (zero_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (arr_vld) begin
      pack_data_d = arr_close ? '0 : merged_data;
      pack_mask_d = arr_close ? '0 : merged_mask;
    end
    if (push) wr_d = (wr_q == PTR_W'(SKID_BEATS - 1)) ? '0 : wr_q + PTR_W'(1);
    if (pop)  rd_d = (rd_q == PTR_W'(SKID_BEATS - 1)) ? '0 : rd_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    case ({re && (lane_q == '0), pop})
      2'b10:   resv_d = resv_q + CNT_W'(1);
      2'b01:   resv_d = resv_q - CNT_W'(1);
      default: resv_d = resv_q;
    endcase
    if (pop_last) begin
      state_d = IDLE;  done_d = 1'b1;
    end
  end

  // State registers; reset also flushes any reads still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;  zero_q <= 1'b0;  done_q <= 1'b0;  addr_q <= '0;
      nf_q <= '0;  nc_q <= '0;  nr_q <= '0;  ns_q <= '0;  rg_q <= '0;  tg_q <= '0;
      f_q <= '0;  c_q <= '0;  row_q <= '0;  col_q <= '0;  cmod_q <= '0;  fmod_q <= '0;
      rowbase_q <= '0;  lane_q <= '0;  resv_q <= '0;  cnt_q <= '0;
      pipe_vld_q <= '0;  pack_data_q <= '0;  pack_mask_q <= '0;  wr_q <= '0;  rd_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) pipe_sb_q[k] <= '0;
    end else begin
      state_q <= state_d;  zero_q <= zero_d;  done_q <= done_d;  addr_q <= addr_d;
      nf_q <= nf_d;  nc_q <= nc_d;  nr_q <= nr_d;  ns_q <= ns_d;  rg_q <= rg_d;  tg_q <= tg_d;
      f_q <= f_d;  c_q <= c_d;  row_q <= row_d;  col_q <= col_d;  cmod_q <= cmod_d;  fmod_q <= fmod_d;
      rowbase_q <= rowbase_d;  lane_q <= lane_d;  resv_q <= resv_d;  cnt_q <= cnt_d;
      pipe_vld_q <= pipe_vld_d;  pack_data_q <= pack_data_d;  pack_mask_q <= pack_mask_d;
      wr_q <= wr_d;  rd_q <= rd_d;
      for (int k = 0; k < RD_LATENCY; k++) pipe_sb_q[k] <= pipe_sb_d[k];
    end
  end

  // Skid buffer storage; occupancy is tracked by cnt_q, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= entry;
  end

endmodule
`default_nettype wire

// File: tb/tb_weight_noc_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_noc_streamer
// Description : Directed jobs checked against a loop-based tensor-walk model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_noc_streamer;

  localparam int DW = 16;
  localparam int PK = 4;
  localparam int AW = 20;

  typedef struct packed {
    logic [DW*PK-1:0] data;
    logic [PK-1:0]    mask;
    logic [3:0]       rt;
    logic [3:0]       ct;
  } beat_t;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    num_f = '0, num_c = '0, R = '0, S = '0, r_grp = '0, t_grp = '0;
  logic          busy, done, re, out_valid;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic [DW*PK-1:0] out_data;
  logic [PK-1:0] out_mask;
  logic [3:0]    row_tag, col_tag;

  int n_pass = 0, n_total = 0;
  int cyc = 0, last_xfer = 0, re_count = 0;
  bit zero_job = 1'b0, mon_count = 1'b0;
  logic [AW-1:0] exp_addr [$];
  beat_t         exp_beat [$];

  weight_noc_streamer #(.RD_LATENCY(3)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .base_addr(base_addr), .num_f(num_f), .num_c(num_c), .R(R), .S(S),
    .r_grp(r_grp), .t_grp(t_grp), .re(re), .addr(addr), .rdata(rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mask(out_mask), .row_tag(row_tag), .col_tag(col_tag)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    logic [AW-1:0] m;
    m = a * 20'd37;
    return m[DW-1:0] ^ 16'h5A5A;
  endfunction

  // GLB model: data returns three cycles after the read.
  logic [DW-1:0] rq [3];
  always @(posedge clk) begin
    rq[0] <= re ? memf(addr) : 16'hDEAD;
    rq[1] <= rq[0];
    rq[2] <= rq[1];
  end
  assign rdata = rq[2];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected reads and beats from a plain nested walk of the tensor.
  task automatic build_model(input logic [AW-1:0] base, input int nf, nc, r, s, rg, tg);
    int rgv, tgv, idx, lane;
    logic [AW-1:0] a;
    beat_t b;
    rgv = (rg == 0) ? 1 : rg;
    tgv = (tg == 0) ? 1 : tg;
    idx = 0;
    for (int f = 0; f < nf; f++)
      for (int c = 0; c < nc; c++)
        for (int row = 0; row < r; row++) begin
          b = '0;
          lane = 0;
          for (int col = 0; col < s; col++) begin
            a = AW'(base + AW'(idx));
            idx++;
            exp_addr.push_back(a);
            b.data[lane*DW +: DW] = memf(a);
            b.mask[lane] = 1'b1;
            lane++;
            if (lane == PK || col == s - 1) begin
              b.rt = 4'((c % rgv) * r + row);
              b.ct = 4'(f % tgv);
              exp_beat.push_back(b);
              b = '0;
              lane = 0;
            end
          end
        end
  endtask

  task automatic launch(input logic [AW-1:0] base, input logic [7:0] nf, nc, r, s, rg, tg);
    zero_job = (nf == 0) || (nc == 0) || (r == 0) || (s == 0);
    base_addr = base; num_f = nf; num_c = nc; R = r; S = s; r_grp = rg; t_grp = tg;
    start = 1'b1;
    step();
    start = 1'b0;
    base_addr = '0; num_f = 8'd3; num_c = 8'd3; R = 8'd3; S = 8'd3; r_grp = 8'd3; t_grp = 8'd3;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready held low 20 cycles
  task automatic run_job(input logic [AW-1:0] base, input logic [7:0] nf, nc, r, s, rg, tg,
                         input int mode, input bit spurious);
    int n;
    bit got;
    if (mode == 2) begin
      out_ready = 1'b0;
      re_count  = 0;
      mon_count = 1'b1;
    end
    launch(base, nf, nc, r, s, rg, tg);
    if (zero_job) begin
      check(done == 1'b1, "zero_done_next_cycle", done, 1);
      check(busy == 1'b1, "zero_busy_one_cycle", busy, 1);
      step();
      check(!busy && !done, "zero_back_idle", {busy, done}, 0);
      return;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 3000) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2 && n < 20) out_ready = 1'b0;
      else out_ready = 1'b1;
      if (mode == 2 && n == 20) begin
        mon_count = 1'b0;
        check(re_count == 16, "stall_reads_reserved", re_count, 16);
      end
      if (spurious) start = (n == 5);
      step();
      n++;
      if (done) got = 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check(got, "done_timeout", n, 0);
    check(exp_addr.size() == 0, "reads_outstanding", exp_addr.size(), 0);
    check(exp_beat.size() == 0, "beats_outstanding", exp_beat.size(), 0);
    step();
    check(!busy && !done, "idle_after_done", {busy, done}, 0);
  endtask

  // Per-cycle comparison of reads, beats, hold stability and done timing.
  beat_t         eb;
  logic [AW-1:0] ea;
  bit            hold_prev = 1'b0, prev_done = 1'b0;
  logic [DW*PK-1:0] prev_data;
  logic [11:0]   prev_meta;
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
      prev_done = 1'b0;
    end else begin
      cyc++;
      if (re) begin
        if (mon_count) re_count++;
        if (exp_addr.size() == 0) check(1'b0, "unexpected_re", addr, 0);
        else begin
          ea = exp_addr.pop_front();
          check(addr == ea, "read_addr", addr, ea);
        end
      end
      if (hold_prev)
        check(out_valid && out_data == prev_data && {out_mask, row_tag, col_tag} == prev_meta,
              "hold_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_beat.size() == 0) check(1'b0, "unexpected_beat", out_data, 0);
        else begin
          eb = exp_beat.pop_front();
          check(out_data == eb.data, "beat_data", out_data, eb.data);
          check({out_mask, row_tag, col_tag} == {eb.mask, eb.rt, eb.ct}, "beat_mask_tags",
                {out_mask, row_tag, col_tag}, {eb.mask, eb.rt, eb.ct});
        end
        last_xfer = cyc;
      end
      if (done) begin
        if (prev_done) check(1'b0, "done_one_cycle", 1, 0);
        if (!zero_job) check(!busy && cyc == last_xfer + 1, "done_after_last_beat", cyc, last_xfer + 1);
      end
      prev_done = done;
      hold_prev = out_valid && !out_ready;
      prev_data = out_data;
      prev_meta = {out_mask, row_tag, col_tag};
    end
  end

  initial begin
    repeat (3) step();
    check({busy, done, re, out_valid} == 4'b0, "reset_ctrl", {busy, done, re, out_valid}, 0);
    check(addr == '0 && out_data == '0 && {out_mask, row_tag, col_tag} == '0, "reset_data", addr, 0);
    reset = 1'b0;
    step();
    check({busy, done, re, out_valid} == 4'b0, "idle_after_reset", {busy, done, re, out_valid}, 0);

    // 1x1x3x3 at 0x100: nine reads, three 3-word beats
    build_model(20'h100, 1, 1, 3, 3, 1, 1);
    check(exp_addr.size() == 9 && exp_addr[0] == 20'h100 && exp_addr[8] == 20'h108,
          "model_addrs", exp_addr[8], 20'h108);
    check(exp_beat.size() == 3 && exp_beat[0].mask == 4'b0111 && exp_beat[2].mask == 4'b0111,
          "model_masks", exp_beat[0].mask, 4'b0111);
    check({exp_beat[0].rt, exp_beat[1].rt, exp_beat[2].rt} == 12'h012, "model_row_tags",
          {exp_beat[0].rt, exp_beat[1].rt, exp_beat[2].rt}, 12'h012);
    run_job(20'h100, 1, 1, 3, 3, 1, 1, 0, 1'b0);

    // S=5 splits 4+1 lanes; address wraps; zero groups act as 1
    build_model(20'hFFFFE, 1, 2, 1, 5, 0, 0);
    check(exp_addr[2] == 20'h0 && exp_beat[1].mask == 4'b0001 && exp_beat[2].rt == 4'd0,
          "model_wrap_split", exp_beat[1].mask, 4'b0001);
    run_job(20'hFFFFE, 1, 2, 1, 5, 0, 0, 0, 1'b0);

    // tag grouping under random backpressure
    build_model(20'h2000, 4, 2, 2, 2, 2, 2);
    check({exp_beat[0].rt, exp_beat[1].rt, exp_beat[2].rt, exp_beat[3].rt} == 16'h0123,
          "model_row_tag_seq", {exp_beat[0].rt, exp_beat[3].rt}, 8'h03);
    check({exp_beat[0].ct, exp_beat[4].ct, exp_beat[8].ct, exp_beat[12].ct} == 16'h0101,
          "model_col_tag_seq", {exp_beat[4].ct, exp_beat[8].ct}, 8'h10);
    run_job(20'h2000, 4, 2, 2, 2, 2, 2, 1, 1'b0);

    // output stalled 20 cycles: 24 words, 16 issue then wait
    build_model(20'h3000, 1, 1, 3, 8, 1, 1);
    run_job(20'h3000, 1, 1, 3, 8, 1, 1, 2, 1'b0);

    // zero dimension
    run_job(20'h4000, 2, 2, 0, 2, 1, 1, 0, 1'b0);

    // second start while busy is ignored
    build_model(20'h40, 1, 2, 2, 3, 1, 1);
    run_job(20'h40, 1, 2, 2, 3, 1, 1, 0, 1'b1);

    // reset in the middle of issuing
    build_model(20'h500, 2, 2, 3, 3, 2, 2);
    launch(20'h500, 2, 2, 3, 3, 2, 2);
    repeat (6) step();
    #2 reset = 1'b1;
    #1;
    check({busy, done, re, out_valid} == 4'b0, "midreset_ctrl", {busy, done, re, out_valid}, 0);
    check(addr == '0 && out_data == '0 && {out_mask, row_tag, col_tag} == '0, "midreset_data", addr, 0);
    exp_addr.delete();
    exp_beat.delete();
    step();
    reset = 1'b0;
    build_model(20'h700, 1, 1, 3, 3, 1, 1);
    run_job(20'h700, 1, 1, 3, 3, 1, 1, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
